vga_text_attr: RTL and testbench

- Parametrised text-mode renderer: converts raster position (vid_active, x_cnt, y_cnt) into 12-bit RGB from an internal character/attribute RAM and an external 8-pixel-wide font ROM.
- Adds configurable grid size, font height, pixel scaling, blink and underline attributes, a hardware cursor, and local-bus readback.
- Sits between the VGA timing generator and the RGB output stage.
- Runs entirely in the dot-clock domain.

---
 rtl/vga_text_attr_if.sv | 24 ++
 rtl/vga_text_attr.sv | 198 +++++++++++++++++++
 tb/tb_vga_text_attr.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_attr_if.sv
// Local-bus bundle for the vga_text_attr renderer:
// strobes, chip selects, address/data and read return.
interface vga_text_attr_if;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_addr;
    logic [31:0] lb_wr_d;
    logic        lb_cs_text_ram;
    logic        lb_cs_ctrl;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;

    modport master (
        output lb_wr, lb_rd, lb_addr, lb_wr_d,
        output lb_cs_text_ram, lb_cs_ctrl,
        input  lb_rd_d, lb_rd_rdy
    );

    modport slave (
        input  lb_wr, lb_rd, lb_addr, lb_wr_d,
        input  lb_cs_text_ram, lb_cs_ctrl,
        output lb_rd_d, lb_rd_rdy
    );
endinterface

// File: rtl/vga_text_attr.sv
// Text-mode renderer: char/attr RAM, external font ROM,
// blink, underline, hardware cursor, 4-clock pixel pipeline.
module vga_text_attr #(
    parameter int COL_BITS     = 7,
    parameter int ROW_BITS     = 5,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int FONT_H_LOG2  = 4,
    parameter int SCALE_X_LOG2 = 1,
    parameter int SCALE_Y_LOG2 = 1,
    parameter int BLINK_LOG2   = 4
) (
    input  logic                   clk_dot,
    input  logic                   reset_n,
    vga_text_attr_if.slave         lb,
    input  logic                   frame_start,
    input  logic                   vid_active,
    input  logic [11:0]            x_cnt,
    input  logic [11:0]            y_cnt,
    output logic [FONT_H_LOG2+7:0] font_addr,
    input  logic [7:0]             font_data,
    output logic [11:0]            rgb,
    output logic                   vid_active_o
);
    localparam int AW = COL_BITS + ROW_BITS;
    localparam int FH = FONT_H_LOG2;
    localparam int BW = BLINK_LOG2 + 1;

    typedef struct packed {
        logic          valid;
        logic          show;
        logic [2:0]    bsel;
        logic [FH-1:0] gline;
        logic          blink_off;
        logic          cur_hit;
        logic          cur_blk;
    } pix_t;

    typedef struct packed {
        pix_t        p;
        logic [19:0] word;
    } cell_t;

    logic [19:0]   mem [2**AW];
    logic [19:0]   vword;
    logic [19:0]   rword;
    logic [19:0]   wword;
    logic [AW-1:0] waddr;
    logic [AW-1:0] vaddr;
    logic [31:0]   rdata;
    logic          rd_en;
    logic          wr_ram;
    logic          wr_ctrl;
    logic [3:0]    ctrl;
    logic [11:0]   cur_row;
    logic [11:0]   cur_col;
    logic [BW-1:0] fcnt;
    logic [11:0]   px;
    logic [11:0]   py;
    logic [11:0]   col;
    logic [11:0]   row;
    pix_t          entry;
    pix_t          s0;
    cell_t         s1;
    cell_t         s2;
    logic [11:0]   pix;
    logic          unused;

    assign waddr   = lb.lb_addr[AW+1:2];
    assign rd_en   = lb.lb_rd && !lb.lb_wr;
    assign wr_ram  = lb.lb_wr && lb.lb_cs_text_ram;
    assign wr_ctrl = lb.lb_wr && lb.lb_cs_ctrl;
    assign rword   = mem[waddr];
    assign wword   = {lb.lb_wr_d[25:24], lb.lb_wr_d[21:20],
                      lb.lb_wr_d[18:16], lb.lb_wr_d[12:0]};
    assign unused  = ^{lb.lb_addr, lb.lb_wr_d, s2.word[7:0]};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            lb.lb_cs_text_ram:
                rdata = {6'd0, rword[19:18], 2'd0, rword[17:16],
                         1'b0, rword[15:13], 3'd0, rword[12:0]};
            lb.lb_cs_ctrl:
                case (lb.lb_addr[3:2])
                    2'd0:    rdata = {28'd0, ctrl};
                    2'd1:    rdata = {4'd0, cur_row, 4'd0, cur_col};
                    2'd2:    rdata = 32'(fcnt);
                    default: rdata = '0;
                endcase
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            ctrl          <= 4'h4;
            cur_row       <= '0;
            cur_col       <= '0;
            fcnt          <= '0;
            lb.lb_rd_d    <= '0;
            lb.lb_rd_rdy  <= 1'b0;
        end else begin
            if (frame_start)
                fcnt <= fcnt + BW'(1);
            if (wr_ctrl && lb.lb_addr[3:2] == 2'd0)
                ctrl <= lb.lb_wr_d[3:0];
            if (wr_ctrl && lb.lb_addr[3:2] == 2'd1) begin
                cur_row <= lb.lb_wr_d[27:16];
                cur_col <= lb.lb_wr_d[11:0];
            end
            lb.lb_rd_rdy <= rd_en;
            if (rd_en)
                lb.lb_rd_d <= rdata;
        end
    end

    assign px    = x_cnt >> SCALE_X_LOG2;
    assign py    = y_cnt >> SCALE_Y_LOG2;
    assign col   = px >> 3;
    assign row   = py >> FH;
    assign vaddr = {row[ROW_BITS-1:0], col[COL_BITS-1:0]};

    // Control state is sampled as the pixel enters the pipeline.
    always_comb begin
        entry.valid     = vid_active;
        entry.show      = ctrl[2] && (col < 12'(COLS))
                          && (row < 12'(ROWS));
        entry.bsel      = ~px[2:0];
        entry.gline     = py[FH-1:0];
        entry.blink_off = ctrl[3] && fcnt[BLINK_LOG2];
        entry.cur_hit   = ctrl[0] && !fcnt[BLINK_LOG2]
                          && (row == cur_row) && (col == cur_col);
        entry.cur_blk   = ctrl[1];
    end

    // Read-first: video sees the word as it was before a same-edge write.
    always_ff @(posedge clk_dot) begin
        if (wr_ram)
            mem[waddr] <= wword;
        vword <= mem[vaddr];
    end

    always_ff @(posedge clk_dot or negedge reset_n) begin
        if (!reset_n) begin
            s0           <= '0;
            s1           <= '0;
            s2           <= '0;
            font_addr    <= '0;
            rgb          <= '0;
            vid_active_o <= 1'b0;
        end else begin
            s0           <= entry;
            s1           <= {s0, vword};
            font_addr    <= {vword[7:0], s0.gline};
            s2           <= s1;
            rgb          <= pix;
            vid_active_o <= s2.p.valid;
        end
    end

    function automatic logic [11:0] colour(
        input logic [2:0] c,
        input logic [1:0] l
    );
        logic [3:0] v;
        v = {2'b00, l} * 4'd5;
        return {c[2] ? v : 4'h0, c[1] ? v : 4'h0, c[0] ? v : 4'h0};
    endfunction

    logic       on;
    logic       swap;
    logic [2:0] fc;
    logic [2:0] bc;
    logic [1:0] fl;
    logic [1:0] bl;

    always_comb begin
        on   = font_data[s2.p.bsel]
               | (s2.word[19] & (&s2.p.gline));
        swap = 1'b0;
        if (s2.p.blink_off && s2.word[18])
            on = 1'b0;
        if (s2.p.cur_hit) begin
            if (s2.p.cur_blk)
                swap = 1'b1;
            else if (&s2.p.gline[FH-1:1])
                on = 1'b1;
        end
        fc  = swap ? s2.word[10:8]  : s2.word[15:13];
        fl  = swap ? s2.word[12:11] : s2.word[17:16];
        bc  = swap ? s2.word[15:13] : s2.word[10:8];
        bl  = swap ? s2.word[17:16] : s2.word[12:11];
        pix = '0;
        if (s2.p.valid && s2.p.show)
            pix = on ? colour(fc, fl) : colour(bc, bl);
    end
endmodule

// File: tb/tb_vga_text_attr.sv
// Bench for vga_text_attr: cycle model with scoreboard
// plus directed literal checks.
`timescale 1ns/1ps
module tb_vga_text_attr;
    logic        clk_dot = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        vid_active = 1'b0;
    logic [11:0] x_cnt = '0;
    logic [11:0] y_cnt = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] rgb;
    logic        vid_active_o;
    int          n_chk = 0;
    int          n_pass = 0;

    vga_text_attr_if bus();

    vga_text_attr dut (
        .clk_dot      (clk_dot),
        .reset_n      (reset_n),
        .lb           (bus),
        .frame_start  (frame_start),
        .vid_active   (vid_active),
        .x_cnt        (x_cnt),
        .y_cnt        (y_cnt),
        .font_addr    (font_addr),
        .font_data    (font_data),
        .rgb          (rgb),
        .vid_active_o (vid_active_o)
    );

    always #5 clk_dot = ~clk_dot;

    function automatic logic [7:0] glyph(input logic [7:0] a, input logic [3:0] l);
        if (a == 8'h41) return (l == 4'd0) ? 8'h80 : 8'h3C;
        return 8'((int'(a) * 7 + int'(l) * 13) % 256);
    endfunction

    always @(posedge clk_dot) font_data <= glyph(font_addr[11:4], font_addr[3:0]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [4096];
    logic [3:0]  m_ctrl = 4'h4;
    logic [11:0] m_row = '0;
    logic [11:0] m_col = '0;
    int          m_cnt = 0;
    logic [11:0] h_rgb [4] = '{default: '0};
    logic        h_va  [4] = '{default: 1'b0};
    logic        e_rdy = 1'b0;
    logic [31:0] e_rd = '0;

    initial for (int i = 0; i < 4096; i++) m_ram[i] = '0;

    function automatic logic [11:0] to12(input int c, input int l);
        logic [3:0] v;
        v = 4'(l * 5);
        return {c[2] ? v : 4'h0, c[1] ? v : 4'h0, c[0] ? v : 4'h0};
    endfunction

    function automatic logic [11:0] exp_pix(input logic va, input int x, input int y);
        int px, py, c, r, gl, b, fg, bg, fl, bl, t;
        logic [31:0] wd;
        logic [7:0] g;
        logic on, off;
        if (!va || !m_ctrl[2]) return '0;
        px = x / 2; py = y / 2;
        c = px / 8; r = py / 16; gl = py % 16; b = 7 - px % 8;
        if (c >= 80 || r >= 30) return '0;
        wd = m_ram[(r % 32) * 128 + (c % 128)];
        g = glyph(wd[7:0], 4'(gl));
        on = g[b] || (wd[25] && gl == 15);
        off = (m_cnt >= 16);
        if (m_ctrl[3] && wd[24] && off) on = 1'b0;
        fg = int'(wd[18:16]); fl = int'(wd[21:20]);
        bg = int'(wd[10:8]);  bl = int'(wd[12:11]);
        if (m_ctrl[0] && !off && r == int'(m_row) && c == int'(m_col)) begin
            if (m_ctrl[1]) begin
                t = fg; fg = bg; bg = t;
                t = fl; fl = bl; bl = t;
            end else if (gl >= 14) on = 1'b1;
        end
        return on ? to12(fg, fl) : to12(bg, bl);
    endfunction

    function automatic logic [31:0] model_read();
        if (bus.lb_cs_text_ram) return m_ram[bus.lb_addr[13:2]];
        if (bus.lb_cs_ctrl)
            case (bus.lb_addr[3:2])
                2'd0:    return {28'd0, m_ctrl};
                2'd1:    return {4'd0, m_row, 4'd0, m_col};
                2'd2:    return 32'(m_cnt);
                default: return '0;
            endcase
        return '0;
    endfunction

    always @(posedge clk_dot) begin
        if (!reset_n) begin
            m_ctrl <= 4'h4; m_row <= '0; m_col <= '0; m_cnt <= 0;
            e_rdy <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_rgb[i] <= '0; h_va[i] <= 1'b0;
            end
        end else begin
            h_rgb[0] <= exp_pix(vid_active, int'(x_cnt), int'(y_cnt));
            h_va[0]  <= vid_active;
            for (int i = 1; i < 4; i++) begin
                h_rgb[i] <= h_rgb[i-1]; h_va[i] <= h_va[i-1];
            end
            e_rdy <= bus.lb_rd && !bus.lb_wr;
            if (bus.lb_rd && !bus.lb_wr) e_rd <= model_read();
            if (bus.lb_wr && bus.lb_cs_text_ram)
                m_ram[bus.lb_addr[13:2]] <= bus.lb_wr_d & 32'h0337_1FFF;
            if (bus.lb_wr && bus.lb_cs_ctrl && bus.lb_addr[3:2] == 2'd0)
                m_ctrl <= bus.lb_wr_d[3:0];
            if (bus.lb_wr && bus.lb_cs_ctrl && bus.lb_addr[3:2] == 2'd1) begin
                m_row <= bus.lb_wr_d[27:16]; m_col <= bus.lb_wr_d[11:0];
            end
            if (frame_start) m_cnt <= (m_cnt + 1) % 32;
        end
    end

    always @(negedge clk_dot) begin
        chk("rgb", 32'(rgb), 32'(h_rgb[3]));
        chk("vid_o", 32'(vid_active_o), 32'(h_va[3]));
        chk("rd_rdy", 32'(bus.lb_rd_rdy), 32'(e_rdy));
        if (e_rdy) chk("rd_d", bus.lb_rd_d, e_rd);
    end

    // ---------------- stimulus ----------------
    task automatic bus_wr(input bit ram, input bit ctl, input logic [31:0] a, input logic [31:0] d);
        bus.lb_wr = 1'b1; bus.lb_cs_text_ram = ram; bus.lb_cs_ctrl = ctl;
        bus.lb_addr = a; bus.lb_wr_d = d;
        @(negedge clk_dot);
        bus.lb_wr = 1'b0; bus.lb_cs_text_ram = 1'b0; bus.lb_cs_ctrl = 1'b0;
    endtask

    task automatic bus_rd(input bit ram, input bit ctl, input logic [31:0] a,
                          input logic [31:0] exp, input string nm);
        bus.lb_rd = 1'b1; bus.lb_cs_text_ram = ram; bus.lb_cs_ctrl = ctl;
        bus.lb_addr = a;
        @(negedge clk_dot);
        bus.lb_rd = 1'b0; bus.lb_cs_text_ram = 1'b0; bus.lb_cs_ctrl = 1'b0;
        chk({nm, "_rdy"}, 32'(bus.lb_rd_rdy), 32'd1);
        chk(nm, bus.lb_rd_d, exp);
    endtask

    task automatic show(input int x, input int y, input logic [11:0] exp, input string nm);
        vid_active = 1'b1; x_cnt = 12'(x); y_cnt = 12'(y);
        repeat (5) @(negedge clk_dot);
        chk(nm, 32'(rgb), 32'(exp));
    endtask

    task automatic scan(input int y, input int x0, input int n);
        vid_active = 1'b1; y_cnt = 12'(y);
        for (int i = 0; i < n; i++) begin
            x_cnt = 12'(x0 + i);
            @(negedge clk_dot);
        end
        vid_active = 1'b0;
        repeat (4) @(negedge clk_dot);
    endtask

    initial begin
        bus.lb_wr = 1'b0; bus.lb_rd = 1'b0; bus.lb_addr = '0; bus.lb_wr_d = '0;
        bus.lb_cs_text_ram = 1'b0; bus.lb_cs_ctrl = 1'b0;
        vid_active = 1'b1;
        repeat (3) @(negedge clk_dot);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_vid_o", 32'(vid_active_o), 32'd0);
        chk("rst_rdy", 32'(bus.lb_rd_rdy), 32'd0);
        chk("rst_rd_d", bus.lb_rd_d, 32'd0);
        chk("rst_font_addr", 32'(font_addr), 32'd0);
        reset_n = 1'b1; vid_active = 1'b0;
        bus_rd(0, 1, 32'h0, 32'h0000_0004, "ctrl_default");

        for (int i = 0; i < 4096; i++) bus_wr(1, 0, 32'(i * 4), 32'h0);

        bus_wr(1, 0, 32'h0, 32'h0033_0741);
        bus_rd(1, 0, 32'h0, 32'h0033_0741, "ram_rb1");
        bus_wr(1, 0, 32'h0, 32'hFFFF_FFFF);
        bus_rd(1, 0, 32'h0, 32'h0337_1FFF, "ram_rb_mask");

        bus_wr(1, 0, 32'h0, 32'h0037_0041);
        vid_active = 1'b1; x_cnt = 12'd0; y_cnt = 12'd0;
        @(negedge clk_dot); x_cnt = 12'd1;
        @(negedge clk_dot); x_cnt = 12'd2;
        @(negedge clk_dot); vid_active = 1'b0; x_cnt = 12'd0;
        chk("lat_pre", 32'(rgb), 32'h000);
        @(negedge clk_dot);
        chk("pix_x0", 32'(rgb), 32'hFFF);
        chk("pix_x0_vid", 32'(vid_active_o), 32'd1);
        @(negedge clk_dot); chk("pix_x1", 32'(rgb), 32'hFFF);
        @(negedge clk_dot); chk("pix_x2", 32'(rgb), 32'h000);

        bus_wr(0, 1, 32'h4, 32'h0002_0005);
        bus_rd(0, 1, 32'h4, 32'h0002_0005, "cursor_rb");
        bus_wr(0, 1, 32'h8, 32'h0000_00FF);
        bus_rd(0, 1, 32'h8, 32'h0, "status_ro");
        bus_rd(0, 1, 32'hC, 32'h0, "idx3");
        bus_rd(0, 0, 32'h0, 32'h0, "no_cs");
        bus.lb_wr = 1'b1; bus.lb_rd = 1'b1; bus.lb_cs_ctrl = 1'b1;
        bus.lb_addr = 32'h4; bus.lb_wr_d = 32'h0002_0005;
        @(negedge clk_dot);
        bus.lb_wr = 1'b0; bus.lb_rd = 1'b0; bus.lb_cs_ctrl = 1'b0;
        chk("wr_rd_no_rdy", 32'(bus.lb_rd_rdy), 32'd0);

        bus_wr(1, 0, 32'(79 * 4), 32'h0024_1A58);
        bus_wr(1, 0, 32'(3712 * 4), 32'h0015_0733);
        scan(0, 0, 40);
        scan(6, 1260, 40);
        scan(956, 0, 24);
        scan(940, 0, 24);

        vid_active = 1'b1; x_cnt = 12'd0; y_cnt = 12'd0;
        @(negedge clk_dot);
        bus_wr(1, 0, 32'h0, 32'h0026_0041);
        repeat (6) @(negedge clk_dot);

        bus_wr(0, 1, 32'h0, 32'h0);
        scan(0, 0, 20);
        bus_wr(0, 1, 32'h0, 32'h4);

        bus_wr(1, 0, 32'h0, 32'h0137_0041);
        bus_wr(0, 1, 32'h0, 32'h0000_000C);
        show(0, 0, 12'hFFF, "blink_on0");
        frame_start = 1'b1;
        repeat (16) @(negedge clk_dot);
        frame_start = 1'b0;
        show(0, 0, 12'h000, "blink_off");
        bus_rd(0, 1, 32'h8, 32'h10, "status16");
        frame_start = 1'b1;
        repeat (16) @(negedge clk_dot);
        frame_start = 1'b0;
        show(0, 0, 12'hFFF, "blink_on1");
        bus_rd(0, 1, 32'h8, 32'h0, "status_wrap");

        bus_wr(0, 1, 32'h0, 32'h4);
        bus_wr(1, 0, 32'(261 * 4), 32'h0037_1142);
        show(80, 64, 12'hFFF, "cell_fg");
        show(84, 64, 12'h00A, "cell_bg");
        bus_wr(0, 1, 32'h0, 32'h7);
        show(80, 64, 12'h00A, "cur_blk_fg");
        show(84, 64, 12'hFFF, "cur_blk_bg");
        bus_wr(0, 1, 32'h0, 32'h5);
        show(84, 92, 12'hFFF, "cur_ul_l14");
        show(84, 94, 12'hFFF, "cur_ul_l15");
        show(88, 90, 12'h00A, "cur_ul_l13");
        show(84, 64, 12'h00A, "cur_ul_l0");
        scan(92, 70, 36);
        scan(88, 70, 36);

        bus_wr(0, 1, 32'h0, 32'h4);
        show(0, 0, 12'hFFF, "pre_reset");
        #2 reset_n = 1'b0;
        #1 chk("async_rgb", 32'(rgb), 32'h0);
        chk("async_vid_o", 32'(vid_active_o), 32'd0);
        repeat (3) @(negedge clk_dot);
        reset_n = 1'b1;
        vid_active = 1'b0;
        bus_rd(0, 1, 32'h0, 32'h0000_0004, "ctrl_after_rst");
        bus_rd(0, 1, 32'h4, 32'h0, "cursor_after_rst");
        bus_rd(1, 0, 32'h0, 32'h0137_0041, "ram_retained");
        show(0, 0, 12'hFFF, "post_reset_pix");
        vid_active = 1'b0;
        repeat (6) @(negedge clk_dot);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
